sub4_operand_ctrl: RTL and testbench
====================================

// Module: sub4_operand_ctrl
// PURPOSE
//   Sequential front/back end for the 4-bit absolute-difference subtractor (SUB4).
//   - Captures operands A then B from board switches on debounced ENTER presses.
//   - Drives both operands to the subtractor.
//   - Registers the subtractor's 4-bit result together with a sign flag.
//   - Holds the registered result stable for the display stage.
// PARAMETERS
//   WIDTH        4     operand/result width; must match the subtractor
//   DEBOUNCE_CYC 1000  cycles a synchronized button level must stay stable to be accepted
// PORTS
//   CLK        in   1      system clock, rising edge
//   RST_N      in   1      synchronous active-low reset
//   SW         in   WIDTH  operand switches, asynchronous
//   BTN_ENTER  in   1      raw ENTER button, asynchronous, bouncy
//   BTN_CLR    in   1      raw CLEAR button, asynchronous
//   SUB_A      out  WIDTH  operand A to subtractor (registered)
//   SUB_B      out  WIDTH  operand B to subtractor (registered)
//   SUB_RES    in   WIDTH  |SUB_A-SUB_B| from subtractor, combinational
//   RESULT     out  WIDTH  registered difference magnitude
//   NEG        out  1      1 when captured A < B
//   VALID      out  1      RESULT/NEG hold a completed computation
//   STATE      out  2      FSM state code, for debug LEDs
// BEHAVIOUR
//   Reset (RST_N=0 at a CLK edge):
//     - All outputs, operand regs, debounce counter and synchronizers go to 0.
//     - FSM goes to S_A.
//   Input conditioning:
//     - BTN_ENTER and BTN_CLR each pass through a 2-flop synchronizer.
//     - ENTER debounce: counter reloads to 0 on any change of the synchronized level.
//     - Debounced level updates only when the counter reaches DEBOUNCE_CYC-1.
//     - press = 1-cycle pulse on the debounced level's 0->1 transition; release generates nothing.
//     - A held button gives exactly one press.
//     - CLR is level-sensitive after sync (no debounce).
//   SW is sampled directly on the press cycle; the user holds the switches steady.
//   FSM states: S_A=00, S_B=01, S_CALC=10, S_SHOW=11.
//     S_A:    press -> SUB_A<=SW, go S_B.
//     S_B:    press -> SUB_B<=SW, go S_CALC.
//     S_CALC: unconditional, one cycle for the subtractor to settle.
//             RESULT<=SUB_RES, NEG<=(SUB_A<SUB_B), VALID<=1, go S_SHOW.
//     S_SHOW: RESULT/NEG/VALID held.
//             press -> SUB_A<=SW, VALID<=0, go S_B (starts the next calculation).
//   Latency: 2 cycles from the press pulse that captures B to VALID=1.
//   Comparison and result:
//     - NEG is an unsigned WIDTH-bit compare.
//     - A==B gives RESULT=0, NEG=0.
//     - RESULT is never recomputed locally; it is always SUB_RES.
//   CLR (synced) high:
//     - Next edge: FSM->S_A, VALID=0, RESULT=0, NEG=0.
//     - SUB_A and SUB_B are kept.
//     - CLR has priority over a press in the same cycle.
//   Reset mid-operation (any state) behaves exactly as power-on reset.
//   press in S_CALC is ignored.
//   VALID, RESULT and NEG change only in S_CALC, on CLR, on reset, or on the S_SHOW->S_B press.
// TESTING (DEBOUNCE_CYC=4 in sim)
//   1 Reset, then A=9 enter, B=3 enter -> 2 cycles after 2nd press: RESULT=6, NEG=0, VALID=1, STATE=11.
//   2 A=3, B=9 -> RESULT=6, NEG=1. A=B=7 -> RESULT=0, NEG=0.
//   3 ENTER bounces 0/1 every 2 cycles for 20 cycles, then held high for 50 cycles ->
//     exactly one press; SUB_A captured once, STATE 00->01 only.
//   4 In S_SHOW, SW=5, press -> VALID=0, SUB_A=5, STATE=01; RESULT keeps its old value until the next S_CALC.
//   5 CLR and ENTER press pulse in the same cycle while in S_B -> STATE=00, VALID=0, SUB_B unchanged.
//   6 RST_N=0 for 1 cycle while in S_CALC -> next cycle all outputs 0, STATE=00; no VALID pulse.

Source files
------------

// File: rtl/sub4_operand_ctrl_if.sv
// Board/subtractor-facing signal bundle for the SUB4 operand controller.
// The slave modport is the controller; the master modport is the board plus subtractor.
interface sub4_operand_ctrl_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] SW;
  logic             BTN_ENTER;
  logic             BTN_CLR;
  logic [WIDTH-1:0] SUB_A;
  logic [WIDTH-1:0] SUB_B;
  logic [WIDTH-1:0] SUB_RES;
  logic [WIDTH-1:0] RESULT;
  logic             NEG;
  logic             VALID;
  logic [1:0]       STATE;

  modport slave (
    input  SW, BTN_ENTER, BTN_CLR, SUB_RES,
    output SUB_A, SUB_B, RESULT, NEG, VALID, STATE
  );

  modport master (
    output SW, BTN_ENTER, BTN_CLR, SUB_RES,
    input  SUB_A, SUB_B, RESULT, NEG, VALID, STATE
  );
endinterface

// File: rtl/sub4_operand_ctrl.sv
// Operand capture, ENTER debounce and result registration around the 4-bit
// absolute-difference subtractor.
module sub4_operand_ctrl #(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned DEBOUNCE_CYC = 1000
) (
  input  logic                CLK,
  input  logic                RST_N,
  sub4_operand_ctrl_if.slave  bus
);
  localparam int unsigned CntW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {
    StA    = 2'b00,
    StB    = 2'b01,
    StCalc = 2'b10,
    StShow = 2'b11
  } state_e;

  state_e           r_state, w_state_nxt;
  logic [1:0]       r_enter_sync, r_clr_sync;
  logic             r_enter_last, r_enter_db, r_enter_db_prev;
  logic [CntW-1:0]  r_db_cnt;
  logic [WIDTH-1:0] r_sub_a, r_sub_b, r_result;
  logic             r_neg, r_valid;
  logic [WIDTH-1:0] w_sub_a_nxt, w_sub_b_nxt, w_result_nxt;
  logic             w_neg_nxt, w_valid_nxt;
  logic             w_press, w_clr;

  // Counter saturates at CntMax so a held level never re-triggers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_enter_sync    <= '0;
      r_clr_sync      <= '0;
      r_enter_last    <= 1'b0;
      r_enter_db      <= 1'b0;
      r_enter_db_prev <= 1'b0;
      r_db_cnt        <= '0;
    end else begin
      r_enter_sync    <= {r_enter_sync[0], bus.BTN_ENTER};
      r_clr_sync      <= {r_clr_sync[0], bus.BTN_CLR};
      r_enter_last    <= r_enter_sync[1];
      r_enter_db_prev <= r_enter_db;
      if (r_enter_sync[1] != r_enter_last) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == CntMax) begin
        r_enter_db <= r_enter_sync[1];
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  assign w_press = r_enter_db & ~r_enter_db_prev;
  assign w_clr   = r_clr_sync[1];

  always_ff @(posedge CLK) begin
    if (!RST_N) r_state <= StA;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_clr) begin
      w_state_nxt = StA;
    end else begin
      unique case (r_state)
        StA:     if (w_press) w_state_nxt = StB;
        StB:     if (w_press) w_state_nxt = StCalc;
        StCalc:  w_state_nxt = StShow;
        StShow:  if (w_press) w_state_nxt = StB;
        default: w_state_nxt = StA;
      endcase
    end
  end

  // CLR wipes the result but keeps the captured operands.
  always_comb begin
    w_sub_a_nxt  = r_sub_a;
    w_sub_b_nxt  = r_sub_b;
    w_result_nxt = r_result;
    w_neg_nxt    = r_neg;
    w_valid_nxt  = r_valid;
    if (w_clr) begin
      w_result_nxt = '0;
      w_neg_nxt    = 1'b0;
      w_valid_nxt  = 1'b0;
    end else begin
      unique case (r_state)
        StA: if (w_press) w_sub_a_nxt = bus.SW;
        StB: if (w_press) w_sub_b_nxt = bus.SW;
        StCalc: begin
          w_result_nxt = bus.SUB_RES;
          w_neg_nxt    = (r_sub_a < r_sub_b);
          w_valid_nxt  = 1'b1;
        end
        StShow: if (w_press) begin
          w_sub_a_nxt = bus.SW;
          w_valid_nxt = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_sub_a  <= '0;
      r_sub_b  <= '0;
      r_result <= '0;
      r_neg    <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_sub_a  <= w_sub_a_nxt;
      r_sub_b  <= w_sub_b_nxt;
      r_result <= w_result_nxt;
      r_neg    <= w_neg_nxt;
      r_valid  <= w_valid_nxt;
    end
  end

  assign bus.SUB_A  = r_sub_a;
  assign bus.SUB_B  = r_sub_b;
  assign bus.RESULT = r_result;
  assign bus.NEG    = r_neg;
  assign bus.VALID  = r_valid;
  assign bus.STATE  = r_state;
endmodule

// File: tb/tb_sub4_operand_ctrl.sv
// Directed + randomized bench for sub4_operand_ctrl with a behavioural subtractor
// and a transaction-level model of the expected operands and result.
module tb_sub4_operand_ctrl;
  logic CLK;
  logic RST_N;

  sub4_operand_ctrl_if #(.WIDTH(4)) bus ();

  sub4_operand_ctrl #(
    .WIDTH        (4),
    .DEBOUNCE_CYC (4)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // External combinational subtractor.
  assign bus.SUB_RES = (bus.SUB_A >= bus.SUB_B) ? (bus.SUB_A - bus.SUB_B) : (bus.SUB_B - bus.SUB_A);

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_a, exp_b, exp_res;
  logic       exp_neg;

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input string tag, input logic [1:0] target, input int bound);
    int n = 0;
    while (bus.STATE !== target && n < bound) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus.STATE), 32'(target));
  endtask

  task automatic enter_a(input logic [3:0] a);
    bus.SW = a;
    bus.BTN_ENTER = 1'b1;
    wait_state("a_reach_sb", 2'b01, 30);
    exp_a = a;
    chk("a_sub_a", 32'(bus.SUB_A), 32'(exp_a));
    chk("a_valid", 32'(bus.VALID), 32'd0);
    chk("a_result_held", 32'(bus.RESULT), 32'(exp_res));
    repeat (4) tick();
    bus.BTN_ENTER = 1'b0;
    repeat (12) tick();
  endtask

  task automatic enter_b(input logic [3:0] b);
    bus.SW = b;
    bus.BTN_ENTER = 1'b1;
    wait_state("b_reach_calc", 2'b10, 30);
    chk("b_calc_valid", 32'(bus.VALID), 32'd0);
    tick();
    exp_b   = b;
    exp_res = (exp_a > exp_b) ? exp_a - exp_b : exp_b - exp_a;
    exp_neg = (exp_a < exp_b);
    chk("b_state_show", 32'(bus.STATE), 32'd3);
    chk("b_valid", 32'(bus.VALID), 32'd1);
    chk("b_result", 32'(bus.RESULT), 32'(exp_res));
    chk("b_neg", 32'(bus.NEG), 32'(exp_neg));
    chk("b_sub_b", 32'(bus.SUB_B), 32'(exp_b));
    repeat (3) tick();
    bus.BTN_ENTER = 1'b0;
    bus.SW = ~b;
    repeat (12) tick();
    chk("b_hold_result", 32'(bus.RESULT), 32'(exp_res));
    chk("b_hold_valid", 32'(bus.VALID), 32'd1);
  endtask

  initial begin
    int changes;
    logic [1:0] prev;
    logic saw_valid;

    RST_N = 1'b0;
    bus.SW = '0;
    bus.BTN_ENTER = 1'b0;
    bus.BTN_CLR = 1'b0;
    exp_a = '0; exp_b = '0; exp_res = '0; exp_neg = 1'b0;
    repeat (3) tick();
    chk("rst_state", 32'(bus.STATE), 32'd0);
    chk("rst_sub_a", 32'(bus.SUB_A), 32'd0);
    chk("rst_sub_b", 32'(bus.SUB_B), 32'd0);
    chk("rst_result", 32'(bus.RESULT), 32'd0);
    chk("rst_neg", 32'(bus.NEG), 32'd0);
    chk("rst_valid", 32'(bus.VALID), 32'd0);
    RST_N = 1'b1;
    repeat (2) tick();

    // Directed operand pairs, then S_SHOW restarts with A=5.
    enter_a(4'd9); enter_b(4'd3);
    enter_a(4'd3); enter_b(4'd9);
    enter_a(4'd7); enter_b(4'd7);
    enter_a(4'd5); enter_b(4'd0);

    for (int i = 0; i < 6; i++) begin
      enter_a(4'($urandom_range(0, 15)));
      enter_b(4'($urandom_range(0, 15)));
    end

    // CLR together with ENTER while in S_B: CLR wins, operands kept.
    enter_a(4'd11);
    bus.SW = 4'd2;
    bus.BTN_CLR = 1'b1;
    bus.BTN_ENTER = 1'b1;
    repeat (14) tick();
    exp_res = '0; exp_neg = 1'b0;
    chk("clr_state", 32'(bus.STATE), 32'd0);
    chk("clr_valid", 32'(bus.VALID), 32'd0);
    chk("clr_result", 32'(bus.RESULT), 32'd0);
    chk("clr_neg", 32'(bus.NEG), 32'd0);
    chk("clr_sub_b", 32'(bus.SUB_B), 32'(exp_b));
    chk("clr_sub_a", 32'(bus.SUB_A), 32'(exp_a));
    bus.BTN_ENTER = 1'b0;
    repeat (12) tick();
    bus.BTN_CLR = 1'b0;
    repeat (4) tick();

    // Bouncy ENTER then a long hold: exactly one press.
    bus.SW = 4'hC;
    changes = 0;
    prev = bus.STATE;
    for (int i = 0; i < 10; i++) begin
      bus.BTN_ENTER = (i % 2 == 0);
      repeat (2) begin
        tick();
        if (bus.STATE !== prev) changes++;
        prev = bus.STATE;
      end
    end
    chk("bounce_no_press", 32'(bus.STATE), 32'd0);
    bus.BTN_ENTER = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (i == 25) bus.SW = 4'h3;
      tick();
      if (bus.STATE !== prev) changes++;
      prev = bus.STATE;
    end
    exp_a = 4'hC;
    chk("bounce_changes", 32'(changes), 32'd1);
    chk("bounce_state", 32'(bus.STATE), 32'd1);
    chk("bounce_sub_a", 32'(bus.SUB_A), 32'(exp_a));
    bus.BTN_ENTER = 1'b0;
    repeat (12) tick();

    // Reset while in S_CALC.
    bus.SW = 4'd1;
    bus.BTN_ENTER = 1'b1;
    wait_state("rst_reach_calc", 2'b10, 30);
    RST_N = 1'b0;
    bus.BTN_ENTER = 1'b0;
    tick();
    chk("mrst_state", 32'(bus.STATE), 32'd0);
    chk("mrst_outs", 32'({bus.SUB_A, bus.SUB_B, bus.RESULT, bus.NEG, bus.VALID}), 32'd0);
    RST_N = 1'b1;
    saw_valid = 1'b0;
    repeat (12) begin
      tick();
      if (bus.VALID !== 1'b0) saw_valid = 1'b1;
    end
    chk("mrst_no_valid", 32'(saw_valid), 32'd0);
    chk("mrst_idle", 32'(bus.STATE), 32'd0);
    exp_a = '0; exp_b = '0; exp_res = '0; exp_neg = 1'b0;

    enter_a(4'd2); enter_b(4'd14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
